// File: rtl/mac_accum_pkg.sv
// Shared parameters and FSM state type for the windowed MAC accumulator.
// Operand width S feeds the upstream multiply-add; N_ACC/ACC_W size the window.
package mac_accum_pkg;

  localparam int S     = 8;
  localparam int N_ACC = 4;
  localparam int CNT_W = $clog2(N_ACC) + 1;
  localparam int ACC_W = 2 * S + $clog2(N_ACC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } acc_state_t;

endpackage

// File: rtl/mac_accum_if.sv
// Input beat stream, clear, result handshake and beat count of mac_accum.
// slave is the accumulator's view, master the producer/consumer side.
interface mac_accum_if
  import mac_accum_pkg::*;
();

  logic [2*S-1:0]   din;
  logic             din_valid;
  logic             din_ready;
  logic             clr;
  logic [ACC_W-1:0] sum;
  logic             sum_valid;
  logic             sum_ready;
  logic [CNT_W-1:0] cnt;

  modport slave (
    input  din,
    input  din_valid,
    output din_ready,
    input  clr,
    output sum,
    output sum_valid,
    input  sum_ready,
    output cnt
  );

  modport master (
    output din,
    output din_valid,
    input  din_ready,
    output clr,
    input  sum,
    input  sum_valid,
    output sum_ready,
    input  cnt
  );

endinterface

// File: rtl/mac_accum.sv
// Sums N_ACC accepted beats into one result and holds it until taken.
// clr drops the current window (and any pending sum) on the next edge.
module mac_accum
  import mac_accum_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  mac_accum_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_ACC - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_ACC);

  acc_state_t       r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_sum;
  logic             r_sum_valid;

  acc_state_t       w_state;
  logic [ACC_W-1:0] w_acc;
  logic [CNT_W-1:0] w_cnt;
  logic [ACC_W-1:0] w_sum;
  logic             w_sum_valid;
  logic [ACC_W-1:0] w_din;
  logic [ACC_W-1:0] w_add;

  assign w_din = ACC_W'(bus.din);
  assign w_add = r_acc + w_din;

  assign bus.din_ready = (r_state != OUT);
  assign bus.sum       = r_sum;
  assign bus.sum_valid = r_sum_valid;
  assign bus.cnt       = r_cnt;

  // Next state, accumulator, counter and result; clr wins over any beat.
  always_comb begin
    w_state     = r_state;
    w_acc       = r_acc;
    w_cnt       = r_cnt;
    w_sum       = r_sum;
    w_sum_valid = r_sum_valid;
    if (bus.clr) begin
      w_state     = IDLE;
      w_acc       = '0;
      w_cnt       = '0;
      w_sum_valid = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.din_valid) begin
            w_acc   = w_din;
            w_cnt   = CNT_W'(1);
            w_state = ACCUM;
          end
        end
        ACCUM: begin
          if (bus.din_valid) begin
            if (r_cnt == CNT_LAST) begin
              w_sum       = w_add;
              w_sum_valid = 1'b1;
              w_cnt       = CNT_FULL;
              w_state     = OUT;
            end else begin
              w_acc = w_add;
              w_cnt = r_cnt + CNT_W'(1);
            end
          end
        end
        OUT: begin
          if (bus.sum_ready) begin
            w_sum_valid = 1'b0;
            w_acc       = '0;
            w_cnt       = '0;
            w_state     = IDLE;
          end
        end
        default: begin
          w_state = IDLE;
        end
      endcase
    end
  end

  // Single register bank for FSM, counter, accumulator and result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_acc       <= w_acc;
      r_cnt       <= w_cnt;
      r_sum       <= w_sum;
      r_sum_valid <= w_sum_valid;
    end
  end

endmodule
